trng_controller: RTL and testbench

TRNG_CONTROLLER -- requirements
Module: trng_controller

---
 rtl/trng_pkg.sv | 33 +++
 rtl/trng_controller_health.sv | 64 ++++++
 rtl/trng_controller.sv | 129 ++++++++++++
 tb/tb_trng_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG controller and its health test.
package trng_pkg;

  localparam int WARMUP_BITS_DEF = 16;
  localparam int BIST_WINDOW_DEF = 64;
  localparam int ONES_MIN_DEF    = 20;
  localparam int ONES_MAX_DEF    = 44;
  localparam int REP_LIMIT_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD,
    S_FAULT
  } state_e;

  // Externally visible state code; WARMUP and COLLECT share one code.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACTIVE = 2'b01;
  localparam logic [1:0] ST_HOLD   = 2'b10;
  localparam logic [1:0] ST_FAULT  = 2'b11;

  function automatic logic [1:0] state_code(input state_e s);
    case (s)
      S_WARMUP, S_COLLECT: return ST_ACTIVE;
      S_HOLD:              return ST_HOLD;
      S_FAULT:             return ST_FAULT;
      default:             return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/trng_controller_health.sv
// Online health test: monobit count per window plus repetition-run detector.
module trng_health_test
  import trng_pkg::*;
#(
  parameter int BIST_WINDOW = BIST_WINDOW_DEF,
  parameter int ONES_MIN    = ONES_MIN_DEF,
  parameter int ONES_MAX    = ONES_MAX_DEF,
  parameter int REP_LIMIT   = REP_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_bit,
  input  logic i_valid,
  output logic o_fail
);

  localparam int WW = $clog2(BIST_WINDOW);

  logic [WW-1:0] r_win;
  logic [WW:0]   r_ones;
  logic [4:0]    r_run;
  logic          r_last;

  logic [WW:0]   w_ones_nx;
  logic [4:0]    w_run_nx;
  logic          w_win_end;
  logic          w_rep_fail;
  logic          w_mono_fail;

  // Next counter values and failure conditions for the bit being accepted.
  always_comb begin
    w_ones_nx = r_ones + (WW+1)'(i_bit);
    w_run_nx  = 5'd1;
    if (r_run != 5'd0 && i_bit == r_last)
      w_run_nx = (r_run >= 5'(REP_LIMIT)) ? 5'(REP_LIMIT) : r_run + 5'd1;
    w_win_end   = (r_win == WW'(BIST_WINDOW - 1));
    w_rep_fail  = (w_run_nx >= 5'(REP_LIMIT));
    w_mono_fail = w_win_end &&
                  ((w_ones_nx < (WW+1)'(ONES_MIN)) || (w_ones_nx > (WW+1)'(ONES_MAX)));
    o_fail      = i_enable & i_valid & (w_rep_fail | w_mono_fail);
  end

  // Counters are zero whenever disabled or cleared; windows restart on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0; r_ones <= '0; r_run <= '0; r_last <= 1'b0;
    end else if (i_clear || !i_enable) begin
      r_win <= '0; r_ones <= '0; r_run <= '0; r_last <= 1'b0;
    end else if (i_valid) begin
      r_run  <= w_run_nx;
      r_last <= i_bit;
      if (w_win_end) begin
        r_win  <= '0;
        r_ones <= '0;
      end else begin
        r_win  <= r_win + WW'(1);
        r_ones <= w_ones_nx;
      end
    end
  end

endmodule

// File: rtl/trng_controller.sv
// TRNG controller: warmup, byte assembly, hold/handshake, health-test fault handling.
module trng_controller
  import trng_pkg::*;
#(
  parameter int WARMUP_BITS = WARMUP_BITS_DEF,
  parameter int BIST_WINDOW = BIST_WINDOW_DEF,
  parameter int ONES_MIN    = ONES_MIN_DEF,
  parameter int ONES_MAX    = ONES_MAX_DEF,
  parameter int REP_LIMIT   = REP_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] src_sel,
  input  logic       bist_en,
  input  logic       req,
  input  logic       req_ss,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       byte_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       unb_clear,
  output logic [1:0] state,
  output logic       bist_fail
);

  localparam int CW = $clog2(WARMUP_BITS + 1);

  state_e        r_state, w_state_nx;
  logic [1:0]    r_src_sel;
  logic          r_req_d, r_pending, r_warm_done, r_unb_clear;
  logic [CW-1:0] r_warm_cnt;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic [7:0]    r_byte_out;
  logic          r_byte_valid, r_bist_fail;

  logic w_src_chg, w_req_ev, w_pend, w_hs, w_acc_bit, w_fail, w_warm_last;

  assign w_src_chg   = (src_sel != r_src_sel);
  assign w_req_ev    = req_ss ? (req & ~r_req_d) : req;
  assign w_pend      = r_pending | w_req_ev;
  // A source change overrides a coincident handshake so the pending request survives.
  assign w_hs        = r_byte_valid & byte_ready & ~w_src_chg;
  assign w_acc_bit   = bit_valid & (r_state == S_COLLECT);
  assign w_warm_last = (r_warm_cnt == CW'(WARMUP_BITS - 1));

  trng_health_test #(
    .BIST_WINDOW(BIST_WINDOW), .ONES_MIN(ONES_MIN),
    .ONES_MAX(ONES_MAX), .REP_LIMIT(REP_LIMIT)
  ) u_health (
    .clk(clk), .rst_n(rst_n), .i_clear(w_src_chg), .i_enable(bist_en),
    .i_bit(bit_in), .i_valid(w_acc_bit), .o_fail(w_fail)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic; a source change beats every other event.
  always_comb begin
    w_state_nx = r_state;
    if (w_src_chg) begin
      w_state_nx = w_pend ? S_WARMUP : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_pend) w_state_nx = r_warm_done ? S_COLLECT : S_WARMUP;
        S_WARMUP:  if (bit_valid && w_warm_last) w_state_nx = S_COLLECT;
        S_COLLECT: if (w_fail) w_state_nx = S_FAULT;
                   else if (bit_valid && r_bit_cnt == 3'd7) w_state_nx = S_HOLD;
        S_HOLD:    if (w_hs) w_state_nx = w_req_ev ? S_COLLECT : S_IDLE;
        default:   w_state_nx = r_state;
      endcase
    end
  end

  // Datapath: request tracking, warmup count, byte assembly, fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_sel <= 2'b00; r_req_d <= 1'b0; r_pending <= 1'b0; r_unb_clear <= 1'b1;
      r_warm_done <= 1'b0; r_warm_cnt <= '0; r_bit_cnt <= '0; r_shift <= '0;
      r_byte_out <= '0; r_byte_valid <= 1'b0; r_bist_fail <= 1'b0;
    end else begin
      r_src_sel   <= src_sel;
      r_req_d     <= req;
      r_unb_clear <= w_src_chg;
      r_pending   <= (w_req_ev & (r_state != S_FAULT)) | (r_pending & ~w_hs);
      if (w_src_chg) begin
        r_warm_done <= 1'b0; r_warm_cnt <= '0; r_bit_cnt <= '0; r_shift <= '0;
        r_byte_valid <= 1'b0; r_bist_fail <= 1'b0;
      end else begin
        case (r_state)
          S_WARMUP: if (bit_valid) begin
            if (w_warm_last) begin
              r_warm_done <= 1'b1;
              r_warm_cnt  <= '0;
            end else begin
              r_warm_cnt <= r_warm_cnt + CW'(1);
            end
          end
          S_COLLECT: if (w_fail) begin
            r_bist_fail <= 1'b1; r_bit_cnt <= '0; r_shift <= '0; r_byte_valid <= 1'b0;
          end else if (bit_valid) begin
            if (r_bit_cnt == 3'd7) begin
              r_byte_out   <= {r_shift, bit_in};
              r_byte_valid <= 1'b1;
              r_bit_cnt    <= '0;
              r_shift      <= '0;
            end else begin
              r_shift   <= {r_shift[5:0], bit_in};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          S_HOLD: if (w_hs) r_byte_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign unb_clear  = r_unb_clear;
  assign bist_fail  = r_bist_fail;
  assign state      = state_code(r_state);

endmodule

// File: tb/tb_trng_controller.sv
// Self-checking bench for trng_controller: directed scenarios plus a randomized
// collect/hold run against a byte-level reference model.
module tb_trng_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] src_sel = 2'b00;
  logic       bist_en = 1'b0, req = 1'b0, req_ss = 1'b0;
  logic       bit_valid = 1'b0, bit_in = 1'b0, byte_ready = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, unb_clear, bist_fail;
  logic [1:0] state;

  int n_pass = 0;
  int n_total = 0;

  trng_controller dut (
    .clk(clk), .rst_n(rst_n), .src_sel(src_sel), .bist_en(bist_en), .req(req),
    .req_ss(req_ss), .bit_valid(bit_valid), .bit_in(bit_in), .byte_ready(byte_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .unb_clear(unb_clear),
    .state(state), .bist_fail(bist_fail)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1; bit_in = b; tick(); bit_valid = 1'b0;
  endtask

  task automatic warmup;
    for (int i = 0; i < 16; i++) send(1'($urandom()));
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req = 1'b0; req_ss = 1'b0; bist_en = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; byte_ready = 1'b0; src_sel = 2'b00;
    tick(); tick();
    rst_n = 1'b1; tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick(); tick();
    n_total++; if (state !== 2'b00) $display("FAIL rst_state: got %b want 00", state); else n_pass++;
    n_total++; if (byte_valid !== 1'b0) $display("FAIL rst_bvalid: got %b want 0", byte_valid); else n_pass++;
    n_total++; if (byte_out !== 8'h00) $display("FAIL rst_bout: got %h want 00", byte_out); else n_pass++;
    n_total++; if (bist_fail !== 1'b0) $display("FAIL rst_bfail: got %b want 0", bist_fail); else n_pass++;
    n_total++; if (unb_clear !== 1'b1) $display("FAIL rst_unb: got %b want 1", unb_clear); else n_pass++;
    rst_n = 1'b1; tick();
    n_total++; if (unb_clear !== 1'b0) $display("FAIL rst_unb_rel: got %b want 0", unb_clear); else n_pass++;
    n_total++; if (state !== 2'b00) $display("FAIL rst_idle: got %b want 00", state); else n_pass++;
  endtask

  // Level request, alternating bits: 16 discarded, then 0xAA.
  task automatic test_basic;
    logic [7:0] exp;
    logic b;
    exp = 8'h00;
    do_reset();
    req = 1'b1; tick();
    n_total++; if (state !== 2'b01) $display("FAIL basic_warm: got %b want 01", state); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      b = (i % 2 == 0);
      if (i >= 16) exp = {exp[6:0], b};
      send(b);
      if (i < 23) begin
        n_total++; if (byte_valid !== 1'b0) $display("FAIL basic_early bit%0d: got %b want 0", i, byte_valid); else n_pass++;
      end
    end
    n_total++; if (byte_valid !== 1'b1) $display("FAIL basic_bvalid: got %b want 1", byte_valid); else n_pass++;
    n_total++; if (byte_out !== exp) $display("FAIL basic_bout: got %h want %h", byte_out, exp); else n_pass++;
    n_total++; if (byte_out !== 8'hAA) $display("FAIL basic_aa: got %h want aa", byte_out); else n_pass++;
    n_total++; if (state !== 2'b10) $display("FAIL basic_hold: got %b want 10", state); else n_pass++;
  endtask

  // Continues from test_basic: hold stable, one handshake, collection resumes.
  task automatic test_hold;
    logic [7:0] exp;
    logic b;
    exp = 8'h00;
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1'($urandom()));
      n_total++; if (byte_out !== 8'hAA || byte_valid !== 1'b1)
        $display("FAIL hold_stable c%0d: got %h/%b want aa/1", i, byte_out, byte_valid); else n_pass++;
    end
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    n_total++; if (byte_valid !== 1'b0) $display("FAIL hold_hs: got %b want 0", byte_valid); else n_pass++;
    n_total++; if (state !== 2'b01) $display("FAIL hold_resume: got %b want 01", state); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      b = 1'($urandom()); exp = {exp[6:0], b}; send(b);
    end
    n_total++; if (byte_valid !== 1'b1 || byte_out !== exp)
      $display("FAIL hold_next: got %b/%h want 1/%h", byte_valid, byte_out, exp); else n_pass++;
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
  endtask

  // Single-shot request held high: exactly one byte.
  task automatic test_single_shot;
    logic b [40];
    logic [7:0] exp;
    int nbytes;
    nbytes = 0; exp = 8'h00;
    do_reset();
    req_ss = 1'b1; byte_ready = 1'b1; req = 1'b1;
    for (int t = 0; t < 40; t++) b[t] = 1'($urandom());
    for (int t = 17; t <= 24; t++) exp = {exp[6:0], b[t]};
    for (int t = 0; t < 40; t++) begin
      send(b[t]);
      if (byte_valid === 1'b1) begin
        nbytes++;
        n_total++; if (byte_out !== exp) $display("FAIL ss_bout: got %h want %h", byte_out, exp); else n_pass++;
      end
    end
    n_total++; if (nbytes !== 1) $display("FAIL ss_count: got %0d want 1", nbytes); else n_pass++;
    n_total++; if (state !== 2'b00) $display("FAIL ss_idle: got %b want 00", state); else n_pass++;
    req = 1'b0; req_ss = 1'b0;
  endtask

  // Run of 16 ones spanning two bytes: second byte suppressed by the fault.
  task automatic test_rep_fault;
    logic [7:0] exp;
    logic b;
    exp = 8'h00;
    do_reset();
    bist_en = 1'b1; req = 1'b1; tick(); warmup();
    for (int i = 0; i < 8; i++) send(1'b1);
    n_total++; if (byte_valid !== 1'b1 || byte_out !== 8'hFF)
      $display("FAIL rep_byte1: got %b/%h want 1/ff", byte_valid, byte_out); else n_pass++;
    byte_ready = 1'b1; tick(); byte_ready = 1'b0;
    for (int i = 8; i < 16; i++) begin
      send(1'b1);
      if (i < 15) begin
        n_total++; if (bist_fail !== 1'b0 || state !== 2'b01)
          $display("FAIL rep_early bit%0d: got %b/%b want 0/01", i, bist_fail, state); else n_pass++;
      end
    end
    n_total++; if (bist_fail !== 1'b1) $display("FAIL rep_flag: got %b want 1", bist_fail); else n_pass++;
    n_total++; if (state !== 2'b11) $display("FAIL rep_state: got %b want 11", state); else n_pass++;
    n_total++; if (byte_valid !== 1'b0) $display("FAIL rep_nobyte: got %b want 0", byte_valid); else n_pass++;
    byte_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(1'($urandom()));
    n_total++; if (state !== 2'b11) $display("FAIL rep_stay: got %b want 11", state); else n_pass++;
    bist_en = 1'b0; tick();
    n_total++; if (bist_fail !== 1'b1) $display("FAIL rep_sticky: got %b want 1", bist_fail); else n_pass++;
    bist_en = 1'b1; byte_ready = 1'b0; src_sel = 2'd2; tick();
    n_total++; if (unb_clear !== 1'b1) $display("FAIL rep_unb: got %b want 1", unb_clear); else n_pass++;
    n_total++; if (bist_fail !== 1'b0) $display("FAIL rep_clr: got %b want 0", bist_fail); else n_pass++;
    n_total++; if (state !== 2'b01) $display("FAIL rep_warm: got %b want 01", state); else n_pass++;
    tick();
    n_total++; if (unb_clear !== 1'b0) $display("FAIL rep_unb_end: got %b want 0", unb_clear); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      b = 1'($urandom());
      if (i >= 16) exp = {exp[6:0], b};
      send(b);
      if (i == 22) begin
        n_total++; if (byte_valid !== 1'b0) $display("FAIL rep_rewarm: got %b want 0", byte_valid); else n_pass++;
      end
    end
    n_total++; if (byte_valid !== 1'b1 || byte_out !== exp)
      $display("FAIL rep_after: got %b/%h want 1/%h", byte_valid, byte_out, exp); else n_pass++;
  endtask

  // One 64-bit window with k ones spread out (randomly rotated).
  task automatic test_monobit(input int k);
    logic pat [64];
    logic [7:0] exp;
    int ones, run, maxrun, r;
    logic exp_fail;
    do_reset();
    bist_en = 1'b1; req = 1'b1; byte_ready = 1'b1; tick(); warmup();
    r = int'($urandom_range(0, 63));
    for (int i = 0; i < 64; i++) pat[i] = 1'b0;
    for (int j = 0; j < k; j++) pat[(j * 64 / k + r) % 64] = 1'b1;
    ones = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 64; i++) begin
      if (pat[i]) ones++;
      run = (i > 0 && pat[i] == pat[i-1]) ? run + 1 : 1;
      if (run > maxrun) maxrun = run;
    end
    exp_fail = (ones < 20) || (ones > 44) || (maxrun >= 16);
    exp = 8'h00;
    for (int i = 0; i < 64; i++) begin
      exp = {exp[6:0], pat[i]};
      send(pat[i]);
      if (i % 8 == 7 && i < 63) begin
        n_total++; if (byte_valid !== 1'b1 || byte_out !== exp || bist_fail !== 1'b0)
          $display("FAIL mono%0d_byte%0d: got %b/%h/%b want 1/%h/0", k, i/8, byte_valid, byte_out, bist_fail, exp); else n_pass++;
        tick();
      end
    end
    n_total++; if (bist_fail !== exp_fail) $display("FAIL mono%0d_flag: got %b want %b", k, bist_fail, exp_fail); else n_pass++;
    n_total++; if (state !== (exp_fail ? 2'b11 : 2'b10)) $display("FAIL mono%0d_state: got %b want %b", k, state, exp_fail ? 2'b11 : 2'b10); else n_pass++;
    n_total++; if (byte_valid !== !exp_fail) $display("FAIL mono%0d_bvalid: got %b want %b", k, byte_valid, !exp_fail); else n_pass++;
  endtask

  // Source change coinciding with the 8th bit.
  task automatic test_src_8th;
    logic [7:0] exp;
    logic b;
    exp = 8'h00;
    do_reset();
    req = 1'b1; byte_ready = 1'b1; tick(); warmup();
    for (int i = 0; i < 7; i++) send(1'($urandom()));
    src_sel = 2'd1; send(1'($urandom()));
    n_total++; if (byte_valid !== 1'b0) $display("FAIL src8_nobyte: got %b want 0", byte_valid); else n_pass++;
    n_total++; if (unb_clear !== 1'b1) $display("FAIL src8_unb: got %b want 1", unb_clear); else n_pass++;
    n_total++; if (state !== 2'b01) $display("FAIL src8_warm: got %b want 01", state); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      b = 1'($urandom());
      if (i >= 16) exp = {exp[6:0], b};
      send(b);
      if (i == 0) begin
        n_total++; if (unb_clear !== 1'b0) $display("FAIL src8_unb_end: got %b want 0", unb_clear); else n_pass++;
      end
      if (i < 23) begin
        n_total++; if (byte_valid !== 1'b0) $display("FAIL src8_early bit%0d: got %b want 0", i, byte_valid); else n_pass++;
      end
    end
    n_total++; if (byte_valid !== 1'b1 || byte_out !== exp)
      $display("FAIL src8_byte: got %b/%h want 1/%h", byte_valid, byte_out, exp); else n_pass++;
  endtask

  // Random valid/ready traffic under a level request against a byte model.
  task automatic test_random;
    logic v, b, rdy, m_hold;
    logic [7:0] m_acc, m_byte;
    int m_cnt;
    m_hold = 1'b0; m_acc = 8'h00; m_byte = 8'h00; m_cnt = 0;
    do_reset();
    req = 1'b1; tick(); warmup();
    for (int t = 0; t < 400; t++) begin
      v = ($urandom_range(0, 3) != 0); b = 1'($urandom()); rdy = ($urandom_range(0, 2) == 0);
      bit_valid = v; bit_in = b; byte_ready = rdy;
      tick();
      if (m_hold) begin
        if (rdy) m_hold = 1'b0;
      end else if (v) begin
        m_acc = {m_acc[6:0], b}; m_cnt++;
        if (m_cnt == 8) begin m_byte = m_acc; m_hold = 1'b1; m_cnt = 0; end
      end
      n_total++; if (byte_valid !== m_hold || (m_hold && byte_out !== m_byte))
        $display("FAIL rand_t%0d: got %b/%h want %b/%h", t, byte_valid, byte_out, m_hold, m_byte); else n_pass++;
    end
    bit_valid = 1'b0; byte_ready = 1'b0;
    // Reset mid-flight drops everything asynchronously.
    #2 rst_n = 1'b0; #1;
    n_total++; if (byte_valid !== 1'b0 || state !== 2'b00 || byte_out !== 8'h00 || unb_clear !== 1'b1)
      $display("FAIL rand_rst: got %b/%b/%h/%b want 0/00/00/1", byte_valid, state, byte_out, unb_clear); else n_pass++;
    tick(); rst_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_single_shot();
    test_rep_fault();
    test_monobit(19);
    test_monobit(20);
    test_src_8th();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
